mano_io_interface: RTL

- Character I/O front end for the Mano basic computer.
- Accepts bytes from an external input device into INPR and raises FGI.
- Drives AC[7:0] out through OUTR with an FGO handshake.
- Owns IEN and the interrupt request flip-flop R.
- INPR feeds the accumulator arithmetic unit's input-transfer path. The OUT path consumes AC low byte.

---
 rtl/mano_io_interface.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mano_io_interface.sv
// rtl/mano_io_interface.sv - Mano basic computer character I/O front end; optional input FIFO under IO_IN_FIFO_EN
module mano_io_interface #(
    parameter int FIFO_AW = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    input  logic [7:0] AC_LO,
    input  logic       INP,
    input  logic       OUT,
    input  logic       SKI,
    input  logic       SKO,
    input  logic       ION,
    input  logic       IOF,
    input  logic       R_SET_EN,
    input  logic       R_CLR,
    output logic [7:0] INPR,
    output logic       FGI,
    output logic       FGO,
    output logic       IEN,
    output logic       R,
    output logic       SKIP,
    output logic       ERR
);

    logic [7:0] inpr_q, inpr_d;
    logic       fgi_q, fgi_d;
    logic [7:0] outr_q, outr_d;
    logic       out_valid_q, out_valid_d;
    logic       ien_q, ien_d;
    logic       r_q, r_d;
    logic       err_q, err_d;
    logic       in_accept;
    logic       fgo;

    // FGO is defined as "OUTR free", so it is simply the inverse of the pending flag
    assign fgo = ~out_valid_q;

`ifdef IO_IN_FIFO_EN
    localparam int CNT_W = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         fifo_mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fifo_pop;

    assign IN_READY = (count_q != {1'b1, {FIFO_AW{1'b0}}});
    // INPR refills only once the CPU has consumed the previous byte
    assign fifo_pop = ~fgi_q & (count_q != '0);

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_accept) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({in_accept, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are meaningless while count is zero, so no reset
    always_ff @(posedge CLK) begin
        if (in_accept) begin
            fifo_mem_q[wr_ptr_q] <= IN_DATA;
        end
    end
`else
    logic [31:0] unused_fifo_aw;

    assign unused_fifo_aw = FIFO_AW;
    assign IN_READY       = ~fgi_q;
`endif

    assign in_accept = IN_VALID & IN_READY;

    // Input register and FGI: load on arrival, release on INP
    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
`ifdef IO_IN_FIFO_EN
        if (fifo_pop) begin
            inpr_d = fifo_mem_q[rd_ptr_q];
            fgi_d  = 1'b1;
        end else if (INP & fgi_q) begin
            fgi_d = 1'b0;
        end
`else
        if (in_accept) begin
            inpr_d = IN_DATA;
            fgi_d  = 1'b1;
        end else if (INP & fgi_q) begin
            fgi_d = 1'b0;
        end
`endif
    end

    // Output register: OUT loads only when OUTR is free; delivery frees it
    always_comb begin
        outr_d      = outr_q;
        out_valid_d = out_valid_q;
        if (OUT & fgo) begin
            outr_d      = AC_LO;
            out_valid_d = 1'b1;
        end
        if (out_valid_q & OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    // Interrupt enable, request flip-flop and sticky protocol error
    always_comb begin
        ien_d = ien_q;
        if (ION) begin
            ien_d = 1'b1;
        end
        if (IOF | R_CLR) begin
            ien_d = 1'b0;
        end
        r_d = r_q;
        if (R_CLR) begin
            r_d = 1'b0;
        end else if (R_SET_EN & ien_q & (fgi_q | fgo)) begin
            r_d = 1'b1;
        end
        err_d = err_q | (INP & ~fgi_q) | (OUT & ~fgo);
    end

    // Architectural state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inpr_q      <= 8'h00;
            fgi_q       <= 1'b0;
            outr_q      <= 8'h00;
            out_valid_q <= 1'b0;
            ien_q       <= 1'b0;
            r_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            inpr_q      <= inpr_d;
            fgi_q       <= fgi_d;
            outr_q      <= outr_d;
            out_valid_q <= out_valid_d;
            ien_q       <= ien_d;
            r_q         <= r_d;
            err_q       <= err_d;
        end
    end

    assign INPR      = inpr_q;
    assign FGI       = fgi_q;
    assign OUT_DATA  = outr_q;
    assign OUT_VALID = out_valid_q;
    assign FGO       = fgo;
    assign IEN       = ien_q;
    assign R         = r_q;
    assign ERR       = err_q;
    assign SKIP      = (SKI & fgi_q) | (SKO & fgo);

endmodule
